uart_rx_responder: RTL and testbench
====================================

// Module: uart_rx_responder
// PURPOSE
//  Bus-responder peripheral on the arbiter data bus: deserialises rxd (8N1) into a receive FIFO.
//  CPU reads status/data, writes control; raises int to the CPU and drops it on int_ack.
//  Counterpart to the CPU-side initiator (daddr/drw/int/int_ack); instanced inside the arbiter.
// PARAMETERS
//  CLK_HZ      50000000  system clock frequency (Hz)
//  BAUD        57600     line rate; DIV = CLK_HZ/(BAUD*16), 16x oversample tick, DIV>=1
//  FIFO_DEPTH  16        receive FIFO entries, power of two, 2..256
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  rst      in   1   asynchronous, active-high reset
//  de       in   1   arbiter select for this peripheral's address window
//  daddr    in   32  byte address; daddr[3:2] selects register
//  drw      in   2   {write,read}; 2'b01 read, 2'b10 write, others idle
//  din      in   32  write data from CPU
//  dout     out  32  read data to CPU
//  rxd      in   1   serial input, async, idle high
//  int      out  1   interrupt request to CPU
//  int_ack  in   1   one-cycle acknowledge from CPU
// BEHAVIOUR
//  Reset: dout=0, int=0, FIFO empty, flags 0, int_en=0, FSM IDLE, rxd sync regs=1.
//  rxd through 2-flop synchroniser; tick = 1-cycle pulse every DIV clocks, free-running.
//  Registers (daddr[3:2]):
//   0 STATUS  r: [0]=not_empty [1]=overrun [2]=frame_err [3]=int_en [12:4]=count, rest 0
//   1 DATA    r: {24'b0,head byte}, pops 1 entry at end of read cycle; empty -> 0, no pop
//   2 CTRL    w: [0]=int_en (stored), [1]=1 clears overrun+frame_err, [2]=1 flushes FIFO
//   3 rsvd    r: 0, w: ignored
//  dout combinational when de && drw==2'b01, else 0; zero wait states.
//  Read side effect only when de && drw==2'b01 && daddr[3:2]==1 on that edge.
//  RX FSM, all counts in ticks:
//   IDLE : synced rxd==0 -> START, tick_cnt=0
//   START: at 8th tick resample; 0 -> DATA (bit=0, tick_cnt=0); 1 -> IDLE (glitch, no flag)
//   DATA : every 16th tick sample into shift reg LSB-first; after bit 7 -> STOP
//   STOP : 16th tick sample; 1 -> push byte; 0 -> frame_err=1, byte discarded; -> IDLE
//  Push when full: byte dropped, overrun=1, FIFO unchanged.
//  Push and pop same cycle: both happen, count unchanged (full case: pop first, push succeeds).
//  Flush same cycle as push or pop: flush wins, count=0, pushed byte lost, no overrun.
//  Flag clear same cycle as set: set wins.
//  Interrupt: int set on clock after a successful push while int_en=1;
//   held until int_ack=1 (cleared next edge); ack and push same cycle -> int stays 1.
//   int_en written 0 clears int immediately (next edge); re-enable does not raise int by itself.
//  count width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
//  rst mid-frame: FSM to IDLE, partial byte discarded, all state to reset values.
// STRUCTURE
//  Shared header uart_defs.vh: register offsets, STATUS/CTRL bit positions, drw encodings.
//  Sub-module uart_rx_fifo (sync FIFO: push, pop, flush, full, empty, count, head).
//  Top of block holds synchroniser, tick divider, RX FSM, register decode, int logic.
// TESTING  (CLK_HZ=1600000, BAUD=100000 -> DIV=1, 16 clk per bit)
//  Send 0xA5 8N1, read STATUS -> 0x00000011; read DATA -> 0x000000A5; STATUS -> 0x00000000.
//  rxd low 4 clk then high -> no push, frame_err=0, FSM back to IDLE.
//  Send 0x3C with stop bit 0 -> count 0, STATUS[2]=1; write CTRL 0x2 -> STATUS[2]=0.
//  Send 17 bytes 0x00..0x10, no reads -> count 16, overrun=1; DATA reads return 0x00..0x0F.
//  CTRL=0x1, send 0x55 -> int=1 until int_ack pulse; next byte re-raises int; ack+push same cycle keeps int=1.
//  Assert rst at DATA bit 4 -> int=0, count=0, dout=0; next full frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_responder_pkg : register map, bus encodings and RX FSM states
// Revision: 1.0
// ---------------------------------------------------------------------------
package uart_rx_responder_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam logic [1:0] DRW_READ  = 2'b01;
    localparam logic [1:0] DRW_WRITE = 2'b10;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_INT_EN    = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 9;

    localparam int CTRL_INT_EN    = 0;
    localparam int CTRL_CLR_FLAGS = 1;
    localparam int CTRL_FLUSH     = 2;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_responder_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_responder_fifo : synchronous byte FIFO with push/pop/flush
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_rx_responder_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [7:0]               data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [7:0]               head_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_responder : 8N1 UART receiver with FIFO, bus registers and interrupt
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_rx_responder
    import uart_rx_responder_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 57600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_i,
    input  logic [31:0] daddr_i,
    input  logic [1:0]  drw_i,
    input  logic [31:0] din_i,
    output logic [31:0] dout_o,
    input  logic        rxd_i,
    output logic        int_o,
    input  logic        int_ack_i
);

    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             sync1_q, sync2_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic             tick;
    logic             rxd_s;

    rx_state_e        state_q, state_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_req;
    logic             frame_set;

    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             int_en_q, int_en_d;
    logic             int_q, int_d;

    logic             rd_en, wr_en, ctrl_wr;
    logic [1:0]       reg_sel;
    logic             pop, flush, clr_flags, push_ok, overrun_set;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_head;
    logic [31:0]      status;
    logic             unused_bits;

    assign unused_bits = ^{daddr_i[31:4], daddr_i[1:0], din_i[31:3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            div_cnt_q <= '0;
        end else begin
            sync1_q   <= rxd_i;
            sync2_q   <= sync1_q;
            div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    assign rxd_s = sync2_q;
    assign tick  = (div_cnt_q == DIV_W'(DIV - 1));

    // Start bit is confirmed at mid-bit; every later sample lands 16 ticks apart.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rxd_s) begin
                    state_d    = RX_START;
                    tick_cnt_d = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rxd_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxd_s, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) state_d = RX_STOP;
                        else                   bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        push_req  = rxd_s;
                        frame_set = !rxd_s;
                        state_d   = RX_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    assign rd_en     = de_i && (drw_i == DRW_READ);
    assign wr_en     = de_i && (drw_i == DRW_WRITE);
    assign reg_sel   = daddr_i[3:2];
    assign ctrl_wr   = wr_en && (reg_sel == REG_CTRL);
    assign pop       = rd_en && (reg_sel == REG_DATA) && !fifo_empty;
    assign flush     = ctrl_wr && din_i[CTRL_FLUSH];
    assign clr_flags = ctrl_wr && din_i[CTRL_CLR_FLAGS];

    assign push_ok     = push_req && !flush && (!fifo_full || pop);
    assign overrun_set = push_req && !flush && fifo_full && !pop;

    uart_rx_responder_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (shift_q),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    // Set beats clear on flags; disabling interrupts beats a new push; push beats ack.
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        int_en_d    = int_en_q;
        int_d       = int_q;
        if (overrun_set)    overrun_d = 1'b1;
        else if (clr_flags) overrun_d = 1'b0;
        if (frame_set)      frame_err_d = 1'b1;
        else if (clr_flags) frame_err_d = 1'b0;
        if (ctrl_wr)        int_en_d = din_i[CTRL_INT_EN];
        if (ctrl_wr && !din_i[CTRL_INT_EN]) int_d = 1'b0;
        else if (push_ok && int_en_q)       int_d = 1'b1;
        else if (int_ack_i)                 int_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            int_en_q    <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            int_en_q    <= int_en_d;
            int_q       <= int_d;
        end
    end

    assign int_o = int_q;

    always_comb begin
        status                              = '0;
        status[ST_NOT_EMPTY]                = !fifo_empty;
        status[ST_OVERRUN]                  = overrun_q;
        status[ST_FRAME_ERR]                = frame_err_q;
        status[ST_INT_EN]                   = int_en_q;
        status[ST_COUNT_LSB +: ST_COUNT_W]  = ST_COUNT_W'(fifo_count);
    end

    always_comb begin
        dout_o = '0;
        if (rd_en) begin
            case (reg_sel)
                REG_STATUS: dout_o = status;
                REG_DATA:   dout_o = fifo_empty ? 32'd0 : {24'd0, fifo_head};
                REG_CTRL:   dout_o = '0;
                REG_RSVD:   dout_o = '0;
                default:    dout_o = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_responder : scoreboard bench for the UART receive responder
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_responder;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int DEPTH  = 16;

    logic        clk;
    logic        rst;
    logic        de;
    logic [31:0] daddr;
    logic [1:0]  drw;
    logic [31:0] din;
    logic [31:0] dout;
    logic        rxd;
    logic        irq;
    logic        int_ack;

    logic [7:0]  sb [$];
    logic        m_ov, m_fe, m_ien;
    int          n_checks;
    int          n_fail;

    uart_rx_responder #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .de_i      (de),
        .daddr_i   (daddr),
        .drw_i     (drw),
        .din_i     (din),
        .dout_o    (dout),
        .rxd_i     (rxd),
        .int_o     (irq),
        .int_ack_i (int_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (sb.size() != 0);
        s[1]    = m_ov;
        s[2]    = m_fe;
        s[3]    = m_ien;
        s[12:4] = 9'(sb.size());
        return s;
    endfunction

    task automatic bus_read(input logic [1:0] rsel, output logic [31:0] data);
        @(negedge clk);
        de    = 1'b1;
        drw   = 2'b01;
        daddr = {28'd0, rsel, 2'b00};
        #1 data = dout;
        @(posedge clk);
        #1;
        de    = 1'b0;
        drw   = 2'b00;
        daddr = '0;
    endtask

    task automatic write_ctrl(input logic [31:0] data);
        @(negedge clk);
        de    = 1'b1;
        drw   = 2'b10;
        daddr = 32'h8;
        din   = data;
        @(posedge clk);
        #1;
        de    = 1'b0;
        drw   = 2'b00;
        daddr = '0;
        din   = '0;
        if (data[2]) sb.delete();
        if (data[1]) begin
            m_ov = 1'b0;
            m_fe = 1'b0;
        end
        m_ien = data[0];
    endtask

    task automatic status_check(input string tag);
        logic [31:0] d;
        bus_read(2'd0, d);
        check_eq(tag, d, exp_status());
    endtask

    task automatic read_data_check(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = (sb.size() != 0) ? {24'd0, sb.pop_front()} : 32'd0;
        bus_read(2'd1, d);
        check_eq(tag, d, e);
    endtask

    // One 8N1 frame, 16 clocks per bit; ack_at/rst_at fire on that clock index of the frame.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int ack_at, input int rst_at);
        int k;
        for (int n = 0; n < 160; n++) begin
            @(negedge clk);
            if (n == rst_at) begin
                rst     = 1'b1;
                rxd     = 1'b1;
                int_ack = 1'b0;
                @(negedge clk);
                rst   = 1'b0;
                sb.delete();
                m_ov  = 1'b0;
                m_fe  = 1'b0;
                m_ien = 1'b0;
                return;
            end
            k       = n / 16;
            rxd     = (k == 0) ? 1'b0 : ((k == 9) ? stop : b[k-1]);
            int_ack = (n == ack_at);
        end
        @(negedge clk);
        rxd     = 1'b1;
        int_ack = 1'b0;
        repeat (4) @(negedge clk);
        if (stop) begin
            if (sb.size() < DEPTH) sb.push_back(b);
            else                   m_ov = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] d;
        clk = 1'b0; rst = 1'b1; de = 1'b0; daddr = '0; drw = 2'b00;
        din = '0; rxd = 1'b1; int_ack = 1'b0;
        m_ov = 1'b0; m_fe = 1'b0; m_ien = 1'b0;
        n_checks = 0; n_fail = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("reset_int", {31'd0, irq}, 32'd0);
        check_eq("reset_dout", dout, 32'd0);
        status_check("reset_status");

        send_byte(8'hA5, 1'b1, -1, -1);
        bus_read(2'd0, d);
        check_eq("status_A5", d, 32'h0000_0011);
        read_data_check("data_A5");
        status_check("status_after_pop");

        @(negedge clk); rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        status_check("glitch_status");

        send_byte(8'h3C, 1'b0, -1, -1);
        status_check("frame_err_set");
        write_ctrl(32'h2);
        status_check("frame_err_clear");

        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, -1, -1);
        status_check("full_overrun");
        for (int i = 0; i < 16; i++) read_data_check("drain");
        read_data_check("data_empty");
        status_check("overrun_sticky");
        write_ctrl(32'h2);

        send_byte(8'h11, 1'b1, -1, -1);
        send_byte(8'h22, 1'b1, -1, -1);
        status_check("pre_flush");
        write_ctrl(32'h4);
        status_check("post_flush");

        write_ctrl(32'h1);
        check_eq("int_idle", {31'd0, irq}, 32'd0);
        send_byte(8'h55, 1'b1, -1, -1);
        check_eq("int_raise", {31'd0, irq}, 32'd1);
        repeat (5) @(negedge clk);
        check_eq("int_held", {31'd0, irq}, 32'd1);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        check_eq("int_acked", {31'd0, irq}, 32'd0);
        status_check("int_status");
        read_data_check("data_55");
        send_byte(8'h66, 1'b1, -1, -1);
        check_eq("int_reraise", {31'd0, irq}, 32'd1);
        send_byte(8'h77, 1'b1, 154, -1);
        check_eq("int_ack_push", {31'd0, irq}, 32'd1);
        write_ctrl(32'h0);
        check_eq("int_disable", {31'd0, irq}, 32'd0);
        write_ctrl(32'h1);
        check_eq("int_reenable", {31'd0, irq}, 32'd0);
        status_check("pre_rst_status");

        send_byte(8'h81, 1'b1, -1, 88);
        check_eq("rst_int", {31'd0, irq}, 32'd0);
        check_eq("rst_dout", dout, 32'd0);
        status_check("rst_status");
        send_byte(8'h81, 1'b1, -1, -1);
        read_data_check("data_81");
        status_check("final_status");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
